pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width (PC, GHR index, taken flag packed by the instantiating stage).
REQ-002 SHALL have parameter DEPTH, default 2: entry count, power of two, 2..8.
REQ-003 SHALL have parameter RESET_VALUE, default 32'hffffffff: value driven on out_data when no valid payload is presented.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-007 SHALL have port in_valid  input  1  upstream payload valid.
REQ-008 SHALL have port in_ready  output  1  buffer accepts payload this cycle.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  output  1  downstream payload valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts payload this cycle.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  oldest payload.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 SHALL implement an in-order FIFO of DEPTH entries with head/tail pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-015 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-016 SHALL drive in_ready = (count != DEPTH) && !flush; no pop-through when full.
REQ-017 SHALL drive out_valid = (count != 0) && !flush (base mode, REQ-027 extends).
REQ-018 SHALL drive out_data = entry at head when out_valid, else RESET_VALUE.
REQ-019 Latency SHALL be 1 cycle: payload pushed in cycle N is presentable in cycle N+1 at the earliest.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including when count==1.
REQ-021 count SHALL update as count + push - pop each cycle; never exceeds DEPTH, never underflows.
REQ-022 flush SHALL take priority over push and pop: pointers and count return to 0 on the next edge, entry contents need not be cleared, no handshake completes in the flush cycle.
REQ-023 Storage array SHALL be written only on push; no other state changes without push, pop, flush or reset.

Reset
REQ-024 While rst is low, count, head, tail SHALL be 0 asynchronously; outputs SHALL be in_ready=1 (if flush low), out_valid=0, out_data=RESET_VALUE, count=0.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately without waiting for a clock edge.
REQ-026 First push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 With macro PIPE_STAGE_BUF_BYPASS_EN defined: when count==0, in_valid=1, out_ready=1, flush=0, the module SHALL present in_data combinationally on out_data with out_valid=1, complete both handshakes, and leave count at 0 (zero-latency pass-through); if out_ready=0 the payload is stored normally.
REQ-028 Without PIPE_STAGE_BUF_BYPASS_EN the module SHALL never combinationally pass in_data to outputs; out_valid depends only on registered state and flush.

Verification
REQ-029 DEPTH=4, reset, push 0x00400000,0x00400004,0x00400008 with out_ready=0 -> count=3, out_data=0x00400000, in_ready=1.
REQ-030 Push 4 entries with out_ready=0 -> count=4, in_ready=0; then push+pop every cycle for 8 cycles -> pops in order with no loss across pointer wrap.
REQ-031 count=2, flush=1 with in_valid=1,out_ready=1 -> no handshake that cycle; next cycle count=0, out_valid=0, out_data=0xffffffff.
REQ-032 count=1, in_valid=1, out_ready=1 for 5 cycles -> count stays 1, each value emerges exactly one cycle after entry (base mode).
REQ-033 rst driven low between edges with count=3 -> count=0, out_valid=0 immediately, before the next clk edge.
REQ-034 With PIPE_STAGE_BUF_BYPASS_EN, empty buffer, in_data=0xbfc00000, in_valid=1, out_ready=1 -> same cycle out_valid=1, out_data=0xbfc00000, count remains 0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//
// Registered pipeline buffer. This is a small in-order FIFO that sits
// between two stages. Each side uses a valid/ready handshake. A push takes
// effect on in_valid && in_ready, and a pop on out_valid && out_ready.
// A payload pushed in cycle N can be presented downstream in cycle N+1 at
// the earliest. A synchronous flush discards every buffered entry. The
// asynchronous active-low reset discards them as well, at once and without
// waiting for a clock edge.
//
// Optional feature macro: PIPE_STAGE_BUF_BYPASS_EN
//   Defined   : when the buffer is empty and the downstream side is ready,
//               in_data passes combinationally to out_data. Both handshakes
//               complete in that cycle and nothing is stored.
//   Undefined : no combinational path runs from in_data or in_valid to the
//               outputs.
//
// Parameters
//   DATA_WIDTH  payload width
//   DEPTH       entry count, a power of two from 2 to 8
//   RESET_VALUE driven on out_data whenever no valid payload is presented
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous reset, active low
//   flush      synchronous discard of all entries; also blocks both handshakes
//   in_valid   upstream payload valid
//   in_ready   buffer can accept a payload this cycle
//   in_data    upstream payload
//   out_valid  downstream payload valid
//   out_ready  downstream accepts the payload this cycle
//   out_data   oldest payload, or RESET_VALUE when out_valid is low
//   count      current occupancy

module pipe_stage_buf #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH       = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(32'hffffffff)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         head_q;
    logic [AW-1:0]         tail_q;
    logic [CW-1:0]         count_q;

    logic empty;
    logic full;
    logic stored_valid;
    logic bypass;
    logic push;
    logic pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_COUNT);
    assign stored_valid = !empty && !flush;

`ifdef PIPE_STAGE_BUF_BYPASS_EN
    // Zero-latency pass-through. This only happens when nothing older is
    // waiting, so ordering is kept. The payload is neither stored nor popped.
    assign bypass = empty && in_valid && out_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // in_ready does not look at out_ready. A full buffer therefore refuses a
    // push even when a pop happens in the same cycle.
    assign in_ready  = !full && !flush;
    assign out_valid = stored_valid || bypass;

    assign push = in_valid && in_ready && !bypass;
    assign pop  = stored_valid && out_ready;

    always_comb begin
        out_data = RESET_VALUE;
        if (bypass) begin
            out_data = in_data;
        end else if (stored_valid) begin
            out_data = mem[head_q];
        end
    end

    assign count = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= ptr_next(tail_q);
            end
            if (pop) begin
                head_q <= ptr_next(head_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset. Only entries between head and tail can be seen,
    // and reset or flush makes that range empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed testbench for pipe_stage_buf with DEPTH=4 and DATA_WIDTH=32.
// A table of hand-computed vectors covers fill, full, flush and refill.
// Hand-written sequences, checked against a small queue model, cover
// pointer wrap, steady push+pop at count 1, mid-cycle reset, and bypass.

module tb_pipe_stage_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RV = 32'hffffffff;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    count;

    int checks;
    int errors;

    logic [31:0] model_q [$];

    pipe_stage_buf #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        orr;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ir, input logic ov,
                           input logic [31:0] od, input logic [2:0] cnt);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_data"},  out_data,       od);
        chk({tag, ".count"},     32'(count),     32'(cnt));
    endtask

    // Starts at posedge+1. Drives the inputs, checks against the queue model
    // at negedge, then advances the model across the next posedge.
    task automatic model_cycle(input string tag, input logic iv, input logic [31:0] d,
                               input logic orr);
        logic        m_push;
        logic        m_pop;
        logic [31:0] exp_od;
        flush     = 1'b0;
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
        @(negedge clk);
        exp_od = (model_q.size() != 0) ? model_q[0] : RV;
        chk_all(tag, model_q.size() != DEPTH, model_q.size() != 0, exp_od, 3'(model_q.size()));
        m_push = iv && (model_q.size() != DEPTH);
        m_pop  = orr && (model_q.size() != 0);
        @(posedge clk);
        #1;
        if (m_pop)  void'(model_q.pop_front());
        if (m_push) model_q.push_back(d);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        //          fl   iv   data           or   ir   ov   out_data       cnt
        vecs[0]  = '{1'b0,1'b1,32'h00400000,1'b0,1'b1,1'b0,32'hffffffff,3'd0};
        vecs[1]  = '{1'b0,1'b1,32'h00400004,1'b0,1'b1,1'b1,32'h00400000,3'd1};
        vecs[2]  = '{1'b0,1'b1,32'h00400008,1'b0,1'b1,1'b1,32'h00400000,3'd2};
        vecs[3]  = '{1'b0,1'b1,32'h0040000c,1'b0,1'b1,1'b1,32'h00400000,3'd3};
        vecs[4]  = '{1'b0,1'b1,32'h00400010,1'b0,1'b0,1'b1,32'h00400000,3'd4};
        vecs[5]  = '{1'b0,1'b1,32'h00400010,1'b1,1'b0,1'b1,32'h00400000,3'd4};
        vecs[6]  = '{1'b0,1'b1,32'h00400010,1'b1,1'b1,1'b1,32'h00400004,3'd3};
        vecs[7]  = '{1'b0,1'b0,32'h00000000,1'b1,1'b1,1'b1,32'h00400008,3'd3};
        vecs[8]  = '{1'b1,1'b1,32'hdeadbeef,1'b1,1'b0,1'b0,32'hffffffff,3'd2};
        vecs[9]  = '{1'b0,1'b0,32'h00000000,1'b0,1'b1,1'b0,32'hffffffff,3'd0};
        vecs[10] = '{1'b0,1'b1,32'h11111111,1'b0,1'b1,1'b0,32'hffffffff,3'd0};
        vecs[11] = '{1'b0,1'b0,32'h00000000,1'b0,1'b1,1'b1,32'h11111111,3'd1};
        vecs[12] = '{1'b0,1'b0,32'h00000000,1'b1,1'b1,1'b1,32'h11111111,3'd1};
        vecs[13] = '{1'b0,1'b0,32'h00000000,1'b0,1'b1,1'b0,32'hffffffff,3'd0};

        #2;
        chk_all("reset", 1'b1, 1'b0, RV, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].orr;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_ov,
                    vecs[i].exp_od, vecs[i].exp_cnt);
            @(posedge clk);
            #1;
        end

        model_q.delete();
        for (int i = 0; i < 4; i++)
            model_cycle($sformatf("fill%0d", i), 1'b1, 32'h00600000 + 32'(i * 4), 1'b0);
        for (int i = 0; i < 8; i++)
            model_cycle($sformatf("wrap%0d", i), 1'b1, 32'h00700000 + 32'(i * 4), 1'b1);
        for (int i = 0; i < 4; i++)
            model_cycle($sformatf("drain%0d", i), 1'b0, 32'h0, 1'b1);
        model_cycle("empty_after_wrap", 1'b0, 32'h0, 1'b0);

        model_cycle("one_prime", 1'b1, 32'h00800000, 1'b0);
        for (int i = 1; i <= 5; i++)
            model_cycle($sformatf("thru%0d", i), 1'b1, 32'h00800000 + 32'(i), 1'b1);
        model_cycle("thru_drain", 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 3; i++)
            model_cycle($sformatf("pre_rst%0d", i), 1'b1, 32'h00900000 + 32'(i), 1'b0);
        in_valid = 1'b0;
        #2;
        chk("pre_rst.count", 32'(count), 32'd3);
        rst = 1'b0;
        #1;
        chk_all("async_rst", 1'b1, 1'b0, RV, 3'd0);
        model_q.delete();
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_cycle("first_push", 1'b1, 32'h00a00000, 1'b0);
        model_cycle("first_pop", 1'b0, 32'h0, 1'b1);

`ifdef PIPE_STAGE_BUF_BYPASS_EN
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hbfc00000;
        out_ready = 1'b1;
        #1;
        chk_all("bypass", 1'b1, 1'b1, 32'hbfc00000, 3'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_all("bypass_after", 1'b1, 1'b0, RV, 3'd0);
        @(posedge clk);
        #1;
`else
        model_cycle("no_bypass", 1'b1, 32'hbfc00000, 1'b1);
        model_cycle("no_bypass_pop", 1'b0, 32'h0, 1'b1);
        model_cycle("no_bypass_empty", 1'b0, 32'h0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
